// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: widths, opcodes and the
// arbiter FSM state encoding.
package alu_pkg;

   // Default datapath and opcode widths
   localparam int ALU_W   = 8;
   localparam int ALU_OPW = 3;

   // Opcodes understood by the downstream ALU top (passed through untouched)
   localparam logic [ALU_OPW-1:0] OP_ADD = 3'd0;
   localparam logic [ALU_OPW-1:0] OP_SUB = 3'd1;
   localparam logic [ALU_OPW-1:0] OP_AND = 3'd2;
   localparam logic [ALU_OPW-1:0] OP_OR  = 3'd3;
   localparam logic [ALU_OPW-1:0] OP_XOR = 3'd4;
   localparam logic [ALU_OPW-1:0] OP_NOT = 3'd5;
   localparam logic [ALU_OPW-1:0] OP_SHL = 3'd6;
   localparam logic [ALU_OPW-1:0] OP_SHR = 3'd7;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage : alu_pkg

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant logic. Grants are combinational and only offered
// while enabled; the pointer moves away from the requester just served when
// that operation completes.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       en,
   input  logic       done,
   input  logic       done_id,
   output logic [1:0] grant,
   output logic       grant_id
);

   // Pointer names the requester favoured when both are asking
   logic ptr_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_grant
         // A requester wins if it asks alone, or if both ask and the pointer favours it
         assign grant[gi] = en && req[gi] && (!req[1-gi] || (ptr_reg == 1'(gi)));
      end
   endgenerate

   assign grant_id = grant[1];

   // Pointer update: after serving requester N, favour the other one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= 1'b0;
      end else if (done) begin
         ptr_reg <= ~done_id;
      end
   end

endmodule : rr_arb2

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin
// arbitration. Each operation is latched on grant, presented to the ALU for
// one cycle, and the registered result is returned with a valid/ready
// handshake tagged with the originating requester.
// Optional build macro ALU_SHARE_ARB_FLAGS_EN adds registered rsp_zero and
// rsp_par result flags.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int W   = ALU_W,
   parameter int OPW = ALU_OPW
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [W-1:0]   req0_A,
   input  logic [W-1:0]   req0_B,
   input  logic [OPW-1:0] req0_op,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [W-1:0]   req1_A,
   input  logic [W-1:0]   req1_B,
   input  logic [OPW-1:0] req1_op,
   output logic [W-1:0]   alu_A,
   output logic [W-1:0]   alu_B,
   output logic [OPW-1:0] alu_op,
   input  logic [W-1:0]   alu_Y,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [W-1:0]   rsp_Y,
   output logic           rsp_id,
`ifdef ALU_SHARE_ARB_FLAGS_EN
   output logic           rsp_zero,
   output logic           rsp_par,
`endif
   output logic           busy
);

   state_t         state_reg;
   logic [W-1:0]   a_reg;
   logic [W-1:0]   b_reg;
   logic [OPW-1:0] op_reg;
   logic           id_reg;
   logic           rsp_valid_reg;
   logic [W-1:0]   rsp_y_reg;
   logic           rsp_id_reg;
   logic           busy_reg;
`ifdef ALU_SHARE_ARB_FLAGS_EN
   logic           rsp_zero_reg;
   logic           rsp_par_reg;
`endif

   logic [1:0]     req_vec;
   logic [1:0]     grant;
   logic           grant_id;
   logic           arb_en;
   logic           arb_done;

   assign req_vec  = {req1_valid, req0_valid};
   assign arb_en   = (state_reg == IDLE);
   assign arb_done = (state_reg == RESP) && rsp_ready;

   rr_arb2 u_rr_arb2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req_vec),
      .en       (arb_en),
      .done     (arb_done),
      .done_id  (id_reg),
      .grant    (grant),
      .grant_id (grant_id)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   // ALU inputs come straight from the latched operands: they only change on
   // a grant, so the ALU sees no toggling outside an operation.
   assign alu_A  = a_reg;
   assign alu_B  = b_reg;
   assign alu_op = op_reg;

   assign rsp_valid = rsp_valid_reg;
   assign rsp_Y     = rsp_y_reg;
   assign rsp_id    = rsp_id_reg;
   assign busy      = busy_reg;
`ifdef ALU_SHARE_ARB_FLAGS_EN
   assign rsp_zero  = rsp_zero_reg;
   assign rsp_par   = rsp_par_reg;
`endif

   // Operation sequencer: latch on grant, sample the ALU in EXEC, hold the
   // result in RESP until the consumer takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         a_reg         <= '0;
         b_reg         <= '0;
         op_reg        <= '0;
         id_reg        <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_y_reg     <= '0;
         rsp_id_reg    <= 1'b0;
         busy_reg      <= 1'b0;
`ifdef ALU_SHARE_ARB_FLAGS_EN
         rsp_zero_reg  <= 1'b0;
         rsp_par_reg   <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (|grant) begin
                  a_reg     <= grant_id ? req1_A  : req0_A;
                  b_reg     <= grant_id ? req1_B  : req0_B;
                  op_reg    <= grant_id ? req1_op : req0_op;
                  id_reg    <= grant_id;
                  busy_reg  <= 1'b1;
                  state_reg <= EXEC;
               end
            end
            EXEC: begin
               rsp_y_reg     <= alu_Y;
               rsp_id_reg    <= id_reg;
               rsp_valid_reg <= 1'b1;
`ifdef ALU_SHARE_ARB_FLAGS_EN
               rsp_zero_reg  <= (alu_Y == '0);
               rsp_par_reg   <= ^alu_Y;
`endif
               state_reg     <= RESP;
            end
            RESP: begin
               // Result and id stay put until the consumer accepts them
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  busy_reg      <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               rsp_valid_reg <= 1'b0;
               busy_reg      <= 1'b0;
               state_reg     <= IDLE;
            end
         endcase
      end
   end

endmodule : alu_share_arbiter

// File: tb/tb_alu_share_arbiter.sv
// Directed testbench for alu_share_arbiter with a behavioural ALU model
// driving alu_Y. Expected results are hand-computed constants.
module tb_alu_share_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req0_ready;
   logic [7:0] req0_A, req0_B;
   logic [2:0] req0_op;
   logic       req1_valid, req1_ready;
   logic [7:0] req1_A, req1_B;
   logic [2:0] req1_op;
   logic [7:0] alu_A, alu_B, alu_Y;
   logic [2:0] alu_op;
   logic       rsp_valid, rsp_ready, rsp_id, busy;
   logic [7:0] rsp_Y;
`ifdef ALU_SHARE_ARB_FLAGS_EN
   logic       rsp_zero, rsp_par;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic drop0 = 1'b1;
   logic drop1 = 1'b1;

   always #5 clk = ~clk;

   alu_share_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_A     (req0_A),
      .req0_B     (req0_B),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_A     (req1_A),
      .req1_B     (req1_B),
      .req1_op    (req1_op),
      .alu_A      (alu_A),
      .alu_B      (alu_B),
      .alu_op     (alu_op),
      .alu_Y      (alu_Y),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_Y      (rsp_Y),
      .rsp_id     (rsp_id),
`ifdef ALU_SHARE_ARB_FLAGS_EN
      .rsp_zero   (rsp_zero),
      .rsp_par    (rsp_par),
`endif
      .busy       (busy)
   );

   // Behavioural stand-in for the shared ALU
   always_comb begin
      alu_Y = 8'h00;
      case (alu_op)
         3'd0: alu_Y = alu_A + alu_B;
         3'd1: alu_Y = alu_A - alu_B;
         3'd2: alu_Y = alu_A & alu_B;
         3'd3: alu_Y = alu_A | alu_B;
         3'd4: alu_Y = alu_A ^ alu_B;
         3'd5: alu_Y = ~alu_A;
         3'd6: alu_Y = alu_A << 1;
         3'd7: alu_Y = alu_A >> 1;
         default: alu_Y = 8'h00;
      endcase
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock from negedge to negedge; drops a request's valid once accepted
   task automatic tick();
      logic a0, a1;
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (a0 && drop0) req0_valid = 1'b0;
      if (a1 && drop1) req1_valid = 1'b0;
      @(negedge clk);
   endtask

   // Advance until a response is shown (bounded), then check it
   task automatic wait_rsp(input string tag, input logic exp_id, input logic [7:0] exp_y);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!rsp_valid && n < 8);
      check_val({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      check_val({tag, "_id"},    32'(rsp_id),    32'(exp_id));
      check_val({tag, "_Y"},     32'(rsp_Y),     32'(exp_y));
      $display("rsp %s: id=%0d Y=0x%02h after %0d cycles", tag, rsp_id, rsp_Y, n);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req0_valid = 1'b0; req0_A = 8'h00; req0_B = 8'h00; req0_op = 3'd0;
      req1_valid = 1'b0; req1_A = 8'h00; req1_B = 8'h00; req1_op = 3'd0;
      rsp_ready = 1'b1;

      // Reset state
      @(negedge clk);
      check_val("rst_valid", 32'(rsp_valid), 32'd0);
      check_val("rst_busy",  32'(busy),      32'd0);
      check_val("rst_Y",     32'(rsp_Y),     32'd0);
      check_val("rst_aluA",  32'(alu_A),     32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single R0 XOR with exact latency
      req0_A = 8'h5A; req0_B = 8'h0F; req0_op = 3'd4; req0_valid = 1'b1;
      #1;
      check_val("t1_ready0", 32'(req0_ready), 32'd1);
      check_val("t1_ready1", 32'(req1_ready), 32'd0);
      tick();
      check_val("t1_exec_ready0", 32'(req0_ready), 32'd0);
      check_val("t1_exec_busy",   32'(busy),       32'd1);
      check_val("t1_exec_valid",  32'(rsp_valid),  32'd0);
      check_val("t1_exec_aluA",   32'(alu_A),      32'h5A);
      check_val("t1_exec_aluop",  32'(alu_op),     32'd4);
      tick();
      check_val("t1_valid", 32'(rsp_valid), 32'd1);
      check_val("t1_Y",     32'(rsp_Y),     32'h55);
      check_val("t1_id",    32'(rsp_id),    32'd0);
      $display("rsp t1: id=%0d Y=0x%02h", rsp_id, rsp_Y);
      tick();
      check_val("t1_done_valid", 32'(rsp_valid), 32'd0);
      check_val("t1_done_busy",  32'(busy),      32'd0);
      check_val("t1_hold_aluA",  32'(alu_A),     32'h5A);

      // Both valid from reset: R0 first, then R1
      do_reset();
      @(negedge clk);
      req0_A = 8'h10; req0_B = 8'h01; req0_op = 3'd0; req0_valid = 1'b1;
      req1_A = 8'hFF; req1_B = 8'hF0; req1_op = 3'd4; req1_valid = 1'b1;
      #1;
      check_val("t2_ready0", 32'(req0_ready), 32'd1);
      check_val("t2_ready1", 32'(req1_ready), 32'd0);
      wait_rsp("t2_r0", 1'b0, 8'h11);
      wait_rsp("t2_r1", 1'b1, 8'h0F);

      // Both held continuously: strict alternation
      drop0 = 1'b0; drop1 = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_rsp("t3_r0", 1'b0, 8'h11);
         wait_rsp("t3_r1", 1'b1, 8'h0F);
      end

      // Back-pressure in RESP with R1 waiting
      tick();
      drop0 = 1'b1; drop1 = 1'b1;
      req0_A = 8'h3C; req0_B = 8'h0F; req0_op = 3'd2;
      req1_A = 8'h20; req1_B = 8'h21; req1_op = 3'd1;
      rsp_ready = 1'b0;
      wait_rsp("t4_r0", 1'b0, 8'h0C);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_val("t4_stall_valid",  32'(rsp_valid),  32'd1);
         check_val("t4_stall_Y",      32'(rsp_Y),      32'h0C);
         check_val("t4_stall_id",     32'(rsp_id),     32'd0);
         check_val("t4_stall_ready1", 32'(req1_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      tick();
      check_val("t4_idle_ready1", 32'(req1_ready), 32'd1);
      check_val("t4_idle_ready0", 32'(req0_ready), 32'd0);
      wait_rsp("t4_r1", 1'b1, 8'hFF);

      // Reset mid-operation: complete one R0 op (pointer moves to R1), then abort one
      req0_A = 8'h0F; req0_B = 8'hF0; req0_op = 3'd3; req0_valid = 1'b1;
      wait_rsp("t5_pre", 1'b0, 8'hFF);
      req0_A = 8'h01; req0_B = 8'h02; req0_op = 3'd0; req0_valid = 1'b1;
      tick();
      tick();
      check_val("t5_exec_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_val("t5_rst_busy",  32'(busy),      32'd0);
      check_val("t5_rst_valid", 32'(rsp_valid), 32'd0);
      check_val("t5_rst_aluA",  32'(alu_A),     32'd0);
      check_val("t5_rst_Y",     32'(rsp_Y),     32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("t5_post_valid", 32'(rsp_valid), 32'd0);
      end
      req0_A = 8'h33; req0_B = 8'h0F; req0_op = 3'd1; req0_valid = 1'b1;
      req1_A = 8'h80; req1_B = 8'h00; req1_op = 3'd7; req1_valid = 1'b1;
      #1;
      check_val("t5_ptr_ready0", 32'(req0_ready), 32'd1);
      check_val("t5_ptr_ready1", 32'(req1_ready), 32'd0);
      wait_rsp("t5_r0", 1'b0, 8'h24);
      wait_rsp("t5_r1", 1'b1, 8'h40);

`ifdef ALU_SHARE_ARB_FLAGS_EN
      // Result flags
      req0_A = 8'hAA; req0_B = 8'hAA; req0_op = 3'd4; req0_valid = 1'b1;
      wait_rsp("t6_zero", 1'b0, 8'h00);
      check_val("t6_zero_flag", 32'(rsp_zero), 32'd1);
      check_val("t6_zero_par",  32'(rsp_par),  32'd0);
      req0_A = 8'h01; req0_B = 8'h00; req0_op = 3'd4; req0_valid = 1'b1;
      wait_rsp("t6_par", 1'b0, 8'h01);
      check_val("t6_par_zero", 32'(rsp_zero), 32'd0);
      check_val("t6_par_flag", 32'(rsp_par),  32'd1);
`endif

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global time limit so the run always terminates
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule : tb_alu_share_arbiter
